led_matrix_scan: RTL and testbench

- Display driver for the 4-column x 8-row LED matrix.
- Sits directly downstream of the CPU output data register. It takes a 32-bit word plus a load strobe and time-multiplexes it onto the 8 row lines and 4 column enables.
- Adds a blanking dead-time between columns to suppress ghosting, and a 4-bit PWM brightness control.
- Optionally double-buffers the word so the display never tears mid-frame.

---
 rtl/led_matrix_scan.sv | 152 +++++++++++++++
 tb/tb_led_matrix_scan.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scan.sv
// led_matrix_scan: display driver for a 4-column x 8-row LED matrix.
//
// It scans one 32-bit display word onto the matrix, one column per slot of DWELL_CYCLES
// clocks. Each slot starts with BLANK_CYCLES of dead time, with every LED and every column
// off, to suppress ghosting. A 4-bit PWM then gates the rows during the rest of the slot.
//
// Optional feature: define LED_SCAN_DBUF_EN to double-buffer the word. In that mode a loaded
// word waits in a pending register and is shown from the next frame boundary, so a frame is
// never torn. Without the macro, a load writes the display register directly.
//
// Ports:
//   clk12MHz     scan clock
//   rst          asynchronous reset, active-high
//   data_in      display word; [31:24] is column 0 ... [7:0] is column 3
//   load         single-cycle strobe that captures data_in
//   brightness   PWM level: 0 is off, 15 is full on; latched once per slot
//   leds         row drive, active-low; leds[i] is bit i of the current column byte
//   lcol         column enables, one-hot, active-high
//   frame_pulse  one-cycle pulse in the first cycle of each frame
//   pending      a loaded word is waiting to be shown (always 0 without LED_SCAN_DBUF_EN)
module led_matrix_scan #(
  parameter int unsigned DWELL_CYCLES = 3000,
  parameter int unsigned BLANK_CYCLES = 64,
  parameter int unsigned CNT_W        = 12
) (
  input  logic        clk12MHz,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        load,
  input  logic [3:0]  brightness,
  output logic [7:0]  leds,
  output logic [3:0]  lcol,
  output logic        frame_pulse,
  output logic        pending
);

  localparam logic [CNT_W-1:0] CntLast  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntBlank = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0] CntLatch = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic {StBlank, StActive} state_e;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       col_q, col_d;
  logic [31:0]      disp_q, disp_d;
  logic [3:0]       bright_q, bright_d;
  logic [7:0]       leds_q, leds_d;
  logic [3:0]       lcol_q, lcol_d;
  logic             frame_q, frame_d;

  state_e      state;
  logic        boundary;
  logic [31:0] show_word;
  logic [7:0]  col_byte;
  logic [3:0]  pwm_phase;
  logic        gate;

`ifdef LED_SCAN_DBUF_EN
  logic [31:0] pdata_q, pdata_d;
  logic        pend_q, pend_d;
`endif

  always_comb begin
    state    = (cnt_q < CntBlank) ? StBlank : StActive;
    boundary = (cnt_q == CntLast) && (col_q == 2'd3);
    cnt_d    = (cnt_q == CntLast) ? '0 : cnt_q + CNT_W'(1);
    col_d    = (cnt_q == CntLast) ? col_q + 2'd1 : col_q;
    bright_d = (cnt_q == CntLatch) ? brightness : bright_q;
    frame_d  = boundary;

`ifdef LED_SCAN_DBUF_EN
    disp_d  = disp_q;
    pdata_d = pdata_q;
    pend_d  = pend_q;
    if (load && boundary) begin
      // A load on the boundary itself skips the pending stage.
      disp_d = data_in;
      pend_d = 1'b0;
    end else begin
      if (boundary && pend_q) begin
        disp_d = pdata_q;
        pend_d = 1'b0;
      end
      if (load) begin
        pdata_d = data_in;
        pend_d  = 1'b1;
      end
    end
    show_word = disp_q;
`else
    disp_d    = load ? data_in : disp_q;
    // Use the incoming word so a load is visible on the very next output cycle.
    show_word = disp_d;
`endif

    unique case (col_q)
      2'd0:    col_byte = show_word[31:24];
      2'd1:    col_byte = show_word[23:16];
      2'd2:    col_byte = show_word[15:8];
      default: col_byte = show_word[7:0];
    endcase

    pwm_phase = 4'(cnt_q - CntBlank);
    gate      = (bright_q == 4'hF) || ((bright_q != 4'h0) && (pwm_phase < bright_q));

    if (state == StBlank) begin
      leds_d = 8'hFF;
      lcol_d = 4'b0000;
    end else begin
      leds_d = gate ? ~col_byte : 8'hFF;
      lcol_d = 4'b0001 << col_q;
    end
  end

  always_ff @(posedge clk12MHz or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      col_q    <= 2'd0;
      disp_q   <= 32'h0;
      bright_q <= 4'h0;
      leds_q   <= 8'hFF;
      lcol_q   <= 4'b0000;
      frame_q  <= 1'b0;
`ifdef LED_SCAN_DBUF_EN
      pdata_q  <= 32'h0;
      pend_q   <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      col_q    <= col_d;
      disp_q   <= disp_d;
      bright_q <= bright_d;
      leds_q   <= leds_d;
      lcol_q   <= lcol_d;
      frame_q  <= frame_d;
`ifdef LED_SCAN_DBUF_EN
      pdata_q  <= pdata_d;
      pend_q   <= pend_d;
`endif
    end
  end

  assign leds        = leds_q;
  assign lcol        = lcol_q;
  assign frame_pulse = frame_q;
`ifdef LED_SCAN_DBUF_EN
  assign pending     = pend_q;
`else
  assign pending     = 1'b0;
`endif

endmodule

// File: tb/tb_led_matrix_scan.sv
module tb_led_matrix_scan;

  localparam int D = 40;
  localparam int B = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        load;
  logic [3:0]  brightness;
  logic [7:0]  leds;
  logic [3:0]  lcol;
  logic        frame_pulse;
  logic        pending;

  led_matrix_scan #(
    .DWELL_CYCLES(D),
    .BLANK_CYCLES(B),
    .CNT_W(6)
  ) dut (
    .clk12MHz   (clk),
    .rst        (rst),
    .data_in    (data_in),
    .load       (load),
    .brightness (brightness),
    .leds       (leds),
    .lcol       (lcol),
    .frame_pulse(frame_pulse),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: n is the number of scan cycles since reset release. Slot position and
  // column come straight from n; the word and brightness follow the load rules.
  int          n;
  logic [31:0] m_disp, m_pdata;
  logic        m_pend;
  logic [3:0]  m_lat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0; m_disp = 0; m_pdata = 0; m_pend = 0; m_lat = 0;
  endtask

  // One clock: outputs after the edge reflect model cycle n with the inputs applied to it.
  task automatic step();
    int c, col, p;
    bit bnd, gate;
    logic [31:0] w;
    logic [7:0] e_leds, byte_v;
    logic [3:0] e_lcol;
    @(posedge clk);
    #1;
    c   = n % D;
    col = (n / D) % 4;
    bnd = (c == D - 1) && (col == 3);
`ifdef LED_SCAN_DBUF_EN
    w = m_disp;
    if (load && bnd) begin
      m_disp = data_in; m_pend = 0;
    end else begin
      if (bnd && m_pend) begin m_disp = m_pdata; m_pend = 0; end
      if (load) begin m_pdata = data_in; m_pend = 1; end
    end
`else
    if (load) m_disp = data_in;
    w = m_disp;
`endif
    byte_v = 8'(w >> (8 * (3 - col)));
    if (c < B) begin
      e_leds = 8'hFF; e_lcol = 4'b0000;
    end else begin
      p      = (c - B) % 16;
      gate   = (m_lat == 15) || (m_lat != 0 && p < int'(m_lat));
      e_leds = gate ? ~byte_v : 8'hFF;
      e_lcol = 4'(1 << col);
    end
    if (c == B - 1) m_lat = brightness;
    chk("leds", leds, e_leds);
    chk("lcol", lcol, e_lcol);
    chk("frame_pulse", frame_pulse, bnd);
    chk("pending", pending, m_pend);
    n++;
  endtask

  task automatic run_to(input int tc, input int tcol);
    bit hit = 0;
    for (int i = 0; i < 4 * D + 2 && !hit; i++) begin
      step();
      if (((n - 1) % D) == tc && (((n - 1) / D) % 4) == tcol) hit = 1;
    end
    chk("run_to_reached", hit, 1);
  endtask

  task automatic do_load(input logic [31:0] d);
    load = 1; data_in = d;
    step();
    load = 0;
  endtask

  initial begin
    int pulses;
    rst = 1; load = 0; data_in = 0; brightness = 0;
    model_reset();
    m_pend = 0;

    // Reset held for five cycles.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("rst_leds", leds, 8'hFF);
      chk("rst_lcol", lcol, 4'b0000);
      chk("rst_frame", frame_pulse, 0);
      chk("rst_pending", pending, 0);
    end
    rst = 0;
    model_reset();

    // Free-running scan with no load: blank first, then column 0 with dark LEDs.
    pulses = 0;
    for (int i = 0; i < 4 * D * 2; i++) begin
      step();
      if (frame_pulse) pulses++;
      if (n - 1 == B - 1) chk("first_blank_lcol", lcol, 4'b0000);
      if (n - 1 == B) chk("first_active_lcol", lcol, 4'b0001);
      if (n - 1 == D + B) chk("col1_lcol", lcol, 4'b0010);
      if (n - 1 == 3 * D + B) chk("col3_lcol", lcol, 4'b1000);
    end
    chk("frame_pulse_count", pulses, 2);

    // Full brightness pattern.
    brightness = 4'd15;
    do_load(32'h8001FF00);
    repeat (4 * D) step();
    run_to(20, 0); chk("pat_col0", leds, 8'h7F);
    run_to(20, 1); chk("pat_col1", leds, 8'hFE);
    run_to(20, 2); chk("pat_col2", leds, 8'h00);
    run_to(20, 3); chk("pat_col3", leds, 8'hFF);
    run_to(3, 0);  chk("pat_blank_leds", leds, 8'hFF); chk("pat_blank_lcol", lcol, 4'b0000);

    // PWM at brightness 4.
    brightness = 4'd4;
    do_load(32'hFFFFFFFF);
    repeat (4 * D) step();
    run_to(B - 1, 1);
    for (int i = 0; i < D - B; i++) begin
      step();
      chk("pwm4", leds, ((i % 16) < 4) ? 8'h00 : 8'hFF);
    end
    brightness = 4'd0;
    run_to(B - 1, 2);
    for (int i = 0; i < D - B; i++) begin
      step();
      chk("pwm0", leds, 8'hFF);
    end
    run_to(20, 3);
    brightness = 4'd15;
    run_to(30, 3); chk("bright_midslot_hold", leds, 8'hFF);
    run_to(30, 0); chk("bright_next_slot", leds, 8'h00);

    // Random loads and brightness changes against the model.
    for (int i = 0; i < 480; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        load = 1; data_in = $urandom;
      end
      if ($urandom_range(0, 31) == 0) brightness = 4'($urandom_range(0, 15));
      step();
      load = 0;
    end

    brightness = 4'd15;
    do_load(32'hFFFFFFFF);
    repeat (4 * D + 10) step();

`ifdef LED_SCAN_DBUF_EN
    run_to(20, 1); do_load(32'hAAAAAAAA); chk("dbuf_pending_set", pending, 1);
    run_to(20, 2); do_load(32'h55555555);
    run_to(20, 3); chk("dbuf_frame_intact", leds, 8'h00); chk("dbuf_pending_hold", pending, 1);
    run_to(20, 0); chk("dbuf_last_wins_c0", leds, 8'hAA); chk("dbuf_pending_clr", pending, 0);
    run_to(20, 1); chk("dbuf_last_wins_c1", leds, 8'hAA);
    run_to(20, 3); do_load(32'h12345678);
    run_to(D - 2, 3); do_load(32'h0F0F0F0F);
    chk("dbuf_bnd_pending", pending, 0);
    run_to(20, 0); chk("dbuf_bnd_c0", leds, 8'hF0);
    run_to(20, 1); chk("dbuf_bnd_c1", leds, 8'hF0);
`else
    run_to(20, 3); chk("direct_before", leds, 8'h00);
    do_load(32'h0000000F);
    chk("direct_after", leds, 8'hF0);
    chk("direct_pending", pending, 0);
`endif

    // Asynchronous reset in the middle of column 2.
    run_to(19, 2);
    chk("pre_rst_lcol", lcol, 4'b0100);
    rst = 1;
    #1;
    chk("async_rst_leds", leds, 8'hFF);
    chk("async_rst_lcol", lcol, 4'b0000);
    chk("async_rst_frame", frame_pulse, 0);
    chk("async_rst_pending", pending, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    run_to(3, 0); chk("restart_blank", lcol, 4'b0000);
    run_to(B, 0); chk("restart_col0", lcol, 4'b0001); chk("restart_dark", leds, 8'hFF);
    repeat (200) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
